// File: rtl/jxfer_sched_if.sv
// jxfer_sched_if -- request/transfer bundle between bus requesters and the
// jxfer_sched transfer scheduler.
//
// Signals:
//   breq    [NREQ]      per-requester request, level-held
//   bsrc    [NREQ*SW]   source register index, requester i at [i*SW +: SW]
//   bdst    [NREQ*SW]   destination register index, same packing
//   bbus1   [NREQ]      move constant 8'h01 via jbus1 instead of a register
//   bgnt    [NREQ]      one-hot grant, held for the whole transfer
//   bdone   [NREQ]      one-cycle completion pulse
//   benable [NREG]      one-hot source enable (jenabler we)
//   bset    [NREG]      one-hot destination set
//   wbit1               jbus1 force-one strobe
//   wbusy               scheduler not idle
// Modports: master = requester side, slave = scheduler side.
interface jxfer_sched_if #(
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int SW   = 2
);
  logic [NREQ-1:0]    breq;
  logic [NREQ*SW-1:0] bsrc;
  logic [NREQ*SW-1:0] bdst;
  logic [NREQ-1:0]    bbus1;
  logic [NREQ-1:0]    bgnt;
  logic [NREQ-1:0]    bdone;
  logic [NREG-1:0]    benable;
  logic [NREG-1:0]    bset;
  logic               wbit1;
  logic               wbusy;

  modport master (
    output breq, bsrc, bdst, bbus1,
    input  bgnt, bdone, benable, bset, wbit1, wbusy
  );

  modport slave (
    input  breq, bsrc, bdst, bbus1,
    output bgnt, bdone, benable, bset, wbit1, wbusy
  );
endinterface

// File: rtl/jxfer_sched.sv
// jxfer_sched -- round-robin bus-transfer scheduler for the 8-bit CPU bus.
// Each granted transfer is sequenced enable -> set -> (hold) on the bus.
//
// Ports:
//   wclk    clock, rising edge
//   wrst_n  asynchronous active-low reset
//   bif     jxfer_sched_if.slave (requests in; grant/done/enable/set/bit1/busy out)
//
// Build option:
//   JXFER_HOLD_EN  defined   -> HOLD state present (4-cycle transfer)
//                  undefined -> SET completes the transfer (3-cycle transfer)
//
// state | meaning
// IDLE  | waiting; picks next requester at/after rr
// ENA   | source enable (or jbus1 strobe) driven
// SET   | enable held, destination set driven
// HOLD  | enable held, set released, bdone pulsed
module jxfer_sched #(
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int SW   = 2
) (
  input  logic           wclk,
  input  logic           wrst_n,
  jxfer_sched_if.slave   bif
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ENA, S_SET, S_HOLD} state_t;

  state_t          r_state;
  logic [RW-1:0]   r_rr;
  logic [SW-1:0]   r_src;
  logic [SW-1:0]   r_dst;
  logic            r_bus1;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [NREG-1:0] r_ena;
  logic [NREG-1:0] r_set;
  logic            r_bit1;
  logic            r_busy;

  logic            w_any;
  logic [RW-1:0]   w_pick;
  logic [RW-1:0]   w_nxt_rr;
  logic [SW-1:0]   w_pk_src;
  logic [SW-1:0]   w_pk_dst;
  logic            w_pk_bus1;
  logic [NREQ-1:0] w_gnt_oh;
  logic [NREG-1:0] w_ena_oh;
  logic [NREG-1:0] w_set_oh;

  // Scan from the highest offset down so the last hit is the one closest
  // to the round-robin pointer.
  always_comb begin
    int idx;
    idx    = 0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(r_rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bif.breq[idx]) begin
        w_any  = 1'b1;
        w_pick = RW'(idx);
      end
    end
  end

  always_comb begin
    w_nxt_rr  = (int'(w_pick) == NREQ - 1) ? '0 : w_pick + RW'(1);
    w_pk_src  = bif.bsrc[int'(w_pick)*SW +: SW];
    w_pk_dst  = bif.bdst[int'(w_pick)*SW +: SW];
    w_pk_bus1 = bif.bbus1[w_pick];
    w_gnt_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
    // src == dst without bus1 is a no-op: nothing is enabled or set.
    w_ena_oh  = (w_pk_bus1 || (w_pk_src == w_pk_dst)) ? '0
                : ({{(NREG-1){1'b0}}, 1'b1} << w_pk_src);
    w_set_oh  = (!r_bus1 && (r_src == r_dst)) ? '0
                : ({{(NREG-1){1'b0}}, 1'b1} << r_dst);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_bus1  <= 1'b0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_ena   <= '0;
      r_set   <= '0;
      r_bit1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_ENA;
            r_rr    <= w_nxt_rr;
            r_src   <= w_pk_src;
            r_dst   <= w_pk_dst;
            r_bus1  <= w_pk_bus1;
            r_gnt   <= w_gnt_oh;
            r_ena   <= w_ena_oh;
            r_bit1  <= w_pk_bus1;
            r_busy  <= 1'b1;
          end
        end
        S_ENA: begin
          r_state <= S_SET;
          r_set   <= w_set_oh;
`ifndef JXFER_HOLD_EN
          // Without HOLD the completion pulse coincides with SET.
          r_done  <= r_gnt;
`endif
        end
        S_SET: begin
`ifdef JXFER_HOLD_EN
          r_state <= S_HOLD;
          r_set   <= '0;
          r_done  <= r_gnt;
`else
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_ena   <= '0;
          r_set   <= '0;
          r_bit1  <= 1'b0;
          r_busy  <= 1'b0;
`endif
        end
        S_HOLD: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_ena   <= '0;
          r_set   <= '0;
          r_bit1  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bif.bgnt    = r_gnt;
  assign bif.bdone   = r_done;
  assign bif.benable = r_ena;
  assign bif.bset    = r_set;
  assign bif.wbit1   = r_bit1;
  assign bif.wbusy   = r_busy;

endmodule

// File: tb/tb_jxfer_sched.sv
// tb_jxfer_sched -- directed self-checking bench for jxfer_sched.
// Follows the JXFER_HOLD_EN setting of the build (D = cycle of bdone).
module tb_jxfer_sched;
  localparam int NREQ = 4;
  localparam int NREG = 4;
  localparam int SW   = 2;
`ifdef JXFER_HOLD_EN
  localparam int D = 3;
`else
  localparam int D = 2;
`endif

  logic wclk;
  logic wrst_n;
  int   n_err;
  int   n_chk;

  jxfer_sched_if #(.NREQ(NREQ), .NREG(NREG), .SW(SW)) bif ();

  jxfer_sched #(.NREQ(NREQ), .NREG(NREG), .SW(SW)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bif    (bif)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string ph, input logic [3:0] g, input logic [3:0] d,
                         input logic [3:0] e, input logic [3:0] s,
                         input logic b1, input logic bz);
    chk({ph, ".bgnt"},    32'(bif.bgnt),    32'(g));
    chk({ph, ".bdone"},   32'(bif.bdone),   32'(d));
    chk({ph, ".benable"}, 32'(bif.benable), 32'(e));
    chk({ph, ".bset"},    32'(bif.bset),    32'(s));
    chk({ph, ".wbit1"},   32'(bif.wbit1),   32'(b1));
    chk({ph, ".wbusy"},   32'(bif.wbusy),   32'(bz));
  endtask

  task automatic set_req(input int i, input logic [1:0] s, input logic [1:0] d,
                         input logic b1, input logic r);
    bif.bsrc[i*SW +: SW] = s;
    bif.bdst[i*SW +: SW] = d;
    bif.bbus1[i]         = b1;
    bif.breq[i]          = r;
  endtask

  // Request of g is already high in the current IDLE cycle (cycle 0).
  // Fields are scrambled after cycle 1 to confirm they were latched.
  task automatic xfer(input string ph, input int g, input logic [1:0] s,
                      input logic [1:0] d, input logic b1, input int drop_at);
    logic [3:0] eg, ee, es, ed;
    logic [1:0] ns, nd;
    eg = 4'(1 << g);
    ee = (b1 || (s == d)) ? 4'b0 : 4'(1 << s);
    for (int c = 1; c <= D; c++) begin
      cyc();
      es = (c == 2 && !(s == d && !b1)) ? 4'(1 << d) : 4'b0;
      ed = (c == D) ? eg : 4'b0;
      chk_out($sformatf("%s.c%0d", ph, c), eg, ed, ee, es, b1, 1'b1);
      if (c == 1) begin
        ns = ~s;
        nd = s;
        bif.bsrc[g*SW +: SW] = ns;
        bif.bdst[g*SW +: SW] = nd;
        bif.bbus1[g]         = ~b1;
      end
      if (c == drop_at) bif.breq[g] = 1'b0;
    end
    cyc();
    chk_out({ph, ".idle"}, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    bif.bsrc[g*SW +: SW] = s;
    bif.bdst[g*SW +: SW] = d;
    bif.bbus1[g]         = b1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    cyc();
    cyc();
    wrst_n = 1'b1;
    cyc();
  endtask

  initial begin
    n_err  = 0;
    n_chk  = 0;
    wrst_n = 1'b0;
    bif.breq  = '0;
    bif.bsrc  = '0;
    bif.bdst  = '0;
    bif.bbus1 = '0;
    #1;
    chk_out("reset", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    do_reset();
    chk_out("post_reset", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    // Single transfer: requester 1, src 2 -> dst 3
    set_req(1, 2'd2, 2'd3, 1'b0, 1'b1);
    xfer("single", 1, 2'd2, 2'd3, 1'b0, D);

    // Bus-1 transfer: requester 0, dst 1, src ignored
    set_req(0, 2'd3, 2'd1, 1'b1, 1'b1);
    xfer("bus1", 0, 2'd3, 2'd1, 1'b1, D);

    // No-op src == dst, request dropped during the transfer
    set_req(3, 2'd2, 2'd2, 1'b0, 1'b1);
    xfer("noop", 3, 2'd2, 2'd2, 1'b0, 1);

    // Contention from reset: order 0,1,2,3 then wrap to 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 2'((i + 1) % NREQ), 1'b0, 1'b1);
    xfer("rr0", 0, 2'd0, 2'd1, 1'b0, D);
    xfer("rr1", 1, 2'd1, 2'd2, 1'b0, D);
    xfer("rr2", 2, 2'd2, 2'd3, 1'b0, D);
    xfer("rr3", 3, 2'd3, 2'd0, 1'b0, D);
    bif.breq = 4'b1111;
    xfer("wrap", 0, 2'd0, 2'd1, 1'b0, D);
    bif.breq = '0;
    cyc();
    chk_out("wrap.quiet", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    // Reset during SET: outputs clear at once, no bdone, rr back to 0
    set_req(1, 2'd0, 2'd2, 1'b0, 1'b1);
    cyc();
    cyc();
    chk("rst.in_set", 32'(bif.bset), 32'h4);
    #1;
    wrst_n = 1'b0;
    #1;
    chk_out("rst.async", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    bif.breq = '0;
    cyc();
    chk_out("rst.held", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    wrst_n = 1'b1;
    cyc();
    chk_out("rst.release", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    set_req(2, 2'd3, 2'd0, 1'b0, 1'b1);
    set_req(0, 2'd1, 2'd3, 1'b0, 1'b1);
    xfer("rst.regrant", 0, 2'd1, 2'd3, 1'b0, D);
    bif.breq = '0;
    cyc();
    chk_out("end", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jxfer_sched.md
# jxfer_sched

Bus-transfer scheduler for the 8-bit CPU bus. It accepts register-to-register transfer requests from several requesters and arbitrates between them round-robin. Each granted transfer is sequenced as enable-then-set-then-hold over the bus: one-hot source enables drive the register `jenabler` gates, one-hot destination sets drive the register latches, and a bus-1 strobe drives `jbus1`. It sits between the control/stepper logic and the register file.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (≥2)
- `NREG`, 4, number of bus registers (power of two)
- `SW`, 2, register index width, equal to log2(`NREG`)

Ports:
- `wclk`  in  1  clock, all state changes on rising edge
- `wrst_n`  in  1  asynchronous, active-low reset
- `breq`  in  NREQ  per-requester request, level-held
- `bsrc`  in  NREQ*SW  source index; requester i uses bits [i*SW +: SW]
- `bdst`  in  NREQ*SW  destination index, same packing as `bsrc`
- `bbus1`  in  NREQ  per-requester flag: transfer constant 8'h01 through `jbus1` instead of a source register
- `bgnt`  out  NREQ  one-hot grant, high for the whole transfer
- `bdone`  out  NREQ  one-cycle completion pulse to the granted requester
- `benable`  out  NREG  one-hot source enable (jenabler `we`)
- `bset`  out  NREG  one-hot destination set
- `wbit1`  out  1  `jbus1` force-one strobe
- `wbusy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ENA, SET, HOLD. All outputs are registered and decoded from the state plus latched fields.
- IDLE: if any `breq` is high, pick the requester at or after pointer `rr` (wrapping modulo `NREQ`). Latch its `bsrc`, `bdst` and `bbus1`, assert its `bgnt`, then go to ENA. If no request is high, stay in IDLE.
- `rr` is set to (granted index + 1) mod `NREQ` when a grant is taken. Reset sets `rr` to 0.
- ENA:
  - If bus1 = 0: `benable[src]` = 1.
  - If bus1 = 1: `wbit1` = 1 and `benable` = 0.
  - Next state: SET.
- SET: ENA outputs are held, and `bset[dst]` = 1. Next state: HOLD.
- HOLD: ENA outputs are held, `bset` = 0, and `bdone[g]` = 1. Next state: IDLE.
- HOLD always returns to IDLE. Each transfer therefore costs one IDLE cycle, which also gives the requester time to drop `breq`.
- The requester must deassert `breq` in the cycle following `bdone`. A `breq` still high in IDLE is treated as a new request.
- Latched fields are frozen during a transfer. Changes on `bsrc`, `bdst` or `bbus1` mid-transfer are ignored.
- If `breq` drops mid-transfer, the transfer still completes and `bdone` still pulses.
- If src == dst and bus1 = 0, the full sequence runs with `benable` and `bset` held at 0 (a no-op), and `bdone` still pulses.
- If bus1 = 1, `bsrc` is ignored.
- At most one bit is high in `bgnt`, `benable` and `bset` at any time.
- On `wrst_n` low, asynchronously and immediately: state goes to IDLE, `rr` to 0, and all outputs to 0. This applies mid-transfer too; the interrupted transfer is dropped and gets no `bdone`.

## Timing
- Request high in IDLE cycle 0:
  - ENA with `bgnt` high in cycle 1
  - SET in cycle 2
  - HOLD with `bdone` in cycle 3
  - IDLE in cycle 4
- Throughput: one transfer per 4 cycles, or 3 cycles with `JXFER_HOLD_EN` undefined.
- The enable leads the set by exactly 1 cycle. With HOLD compiled in, the enable also trails the set by exactly 1 cycle.
- Reset value of every output: 0.

## Configuration
- `JXFER_HOLD_EN` defined: the HOLD state is present, as described above.
- `JXFER_HOLD_EN` undefined:
  - The HOLD state is removed.
  - SET asserts `bdone` and goes directly to IDLE.
  - The enable drops in the same cycle as the set; latency is 3 cycles.

## Test plan
- Single request, HOLD compiled in: requester 1 with src=2, dst=3, bus1=0 -> `bgnt`=4'b0010 in cycles 1-3; `benable`=4'b0100 in cycles 1-3; `bset`=4'b1000 in cycle 2 only; `bdone`=4'b0010 in cycle 3.
- Contention: `breq`=4'b1111 held, each requester dropping its line after its own `bdone` -> grants in order 0,1,2,3 after reset; starting again with all four high, the next grant is 0 (wrap).
- Bus-1 transfer: requester 0 with bus1=1, dst=1 -> `wbit1`=1 in cycles 1-3; `benable`=0 throughout; `bset`=4'b0010 in cycle 2.
- No-op: src=dst=2, bus1=0 -> `benable` and `bset` stay 0; `bdone` pulses in cycle 3; `wbusy` is high in cycles 1-3.
- Reset mid-transfer: `wrst_n` low during SET -> all outputs 0 before the next edge; no `bdone`; after release, a request from requester 2 with requester 0 also pending grants requester 0.
- `JXFER_HOLD_EN` undefined: a single transfer gives `bdone` in cycle 2, and `benable` and `bset` both fall at the end of cycle 2.
